// File: rtl/regfile_mp.sv
// ============================================================================
//  Module      : regfile_mp
//  Description : Parametrised register file with NREAD combinational read
//                ports, one synchronous write port, hardwired-zero register 0
//                and a sequential clear engine that zeroes registers
//                1..DEPTH-1, one per clock.
//  Options     : REGFILE_BYPASS_EN - when defined, a write in flight is
//                forwarded to any read port addressing the same register
//                (write-first). Undefined: reads show stored contents only.
//  Ports       : clk    - clock, all state updates on rising edge
//                reset  - asynchronous active-high reset
//                we/wa/wd - write enable / address / data
//                ra     - NREAD packed read addresses (port i at i*AW)
//                rd     - NREAD packed read data (port i at i*WIDTH)
//                clr    - request sequential clear of registers 1..DEPTH-1
//                busy   - clear engine active (state flop)
//                wdrop  - a requested write is being ignored (busy)
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module regfile_mp #(
    parameter int  WIDTH = 32,
    parameter int  DEPTH = 32,
    parameter int  NREAD = 2,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   we,
    input  logic [AW-1:0]          wa,
    input  logic [WIDTH-1:0]       wd,
    input  logic [NREAD*AW-1:0]    ra,
    output logic [NREAD*WIDTH-1:0] rd,
    input  logic                   clr,
    output logic                   busy,
    output logic                   wdrop
);

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } state_t;

    localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH - 1);

    state_t           state;
    logic [AW-1:0]    ci;
    logic [WIDTH-1:0] regs [DEPTH];
    logic             wr_en;

    // busy comes straight from the state flop, so it is glitch-free.
    assign busy  = (state == CLEAR);
    assign wdrop = we & busy;
    // Register 0 is never written; writes are locked out while clearing.
    assign wr_en = we & ~busy & (wa != '0);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            ci    <= '0;
            for (int k = 0; k < DEPTH; k++) begin
                regs[k] <= '0;
            end
        end else begin
            case (state)
                IDLE: begin
                    // The edge that accepts clr clears nothing yet.
                    if (clr) begin
                        state <= CLEAR;
                        ci    <= AW'(1);
                    end
                end
                CLEAR: begin
                    regs[ci] <= '0;
                    // ci wraps to 0 after the last register (DEPTH is 2^AW).
                    ci       <= ci + 1'b1;
                    if (ci == LAST_IDX) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
            // wr_en is never active in CLEAR, so this cannot collide with
            // the clear write above.
            if (wr_en) begin
                regs[wa] <= wd;
            end
        end
    end

    for (genvar i = 0; i < NREAD; i++) begin : g_rd
        logic [AW-1:0]    addr;
        logic [WIDTH-1:0] data;

        assign addr = ra[i*AW +: AW];

        always_comb begin
            data = (addr == '0) ? '0 : regs[addr];
`ifdef REGFILE_BYPASS_EN
            // wr_en already excludes address 0 and dropped writes.
            if (wr_en && (addr == wa)) begin
                data = wd;
            end
`endif
        end

        assign rd[i*WIDTH +: WIDTH] = data;
    end

endmodule

`default_nettype wire

// File: doc/regfile_mp.md
# regfile_mp

Parametrised multi-read-port register file with asynchronous reset and a sequential clear engine; successor to the fixed two-read, one-write 32x32 register file in the processor datapath. It provides NREAD combinational read ports, one synchronous write port, a hardwired-zero register 0, and an optional same-cycle write-to-read bypass. It sits between decode (read addresses) and writeback (write port) in the pipeline.

## Interface
- WIDTH, 32, data bits per register
- DEPTH, 32, number of registers; power of two, minimum 2; AW = $clog2(DEPTH)
- NREAD, 2, number of read ports, minimum 1
- clk  input  1  clock, all state updates on rising edge
- reset  input  1  asynchronous, active-high; clears all registers and the clear engine
- we  input  1  write enable
- wa  input  AW  write address
- wd  input  WIDTH  write data
- ra  input  NREAD*AW  read addresses; port i uses ra[i*AW +: AW]
- rd  output  NREAD*WIDTH  read data; port i on rd[i*WIDTH +: WIDTH]
- clr  input  1  request sequential clear of registers 1..DEPTH-1
- busy  output  1  clear engine active (registered)
- wdrop  output  1  combinational; high when we=1 is ignored because busy=1

## Operation
- Storage: DEPTH x WIDTH flops; register 0 is always read as 0 and never written.
- Write: on rising edge, if we=1, busy=0 and wa!=0, reg[wa] <= wd. Otherwise no change.
- Read: each port is combinational, rd_i = (ra_i==0) ? 0 : reg[ra_i]. Any number of ports may read the same address in the same cycle; all return identical data.
- Clear engine states: IDLE, CLEAR.
  - IDLE: if clr=1 at a rising edge -> CLEAR, index ci <= 1. No registers change on that edge (a concurrent write is performed normally).
  - CLEAR: each rising edge writes reg[ci] <= 0, ci <= ci+1; on the edge where ci==DEPTH-1, go to IDLE.
  - clr is ignored while in CLEAR (no restart, no extension).
- busy = (state==CLEAR). While busy=1: all writes dropped, wdrop = we; reads keep returning current contents (partially cleared file is visible).
- wdrop = we & busy; 0 in IDLE.
- Reset (any time, including mid-CLEAR): all registers 0, state IDLE, ci 0, busy 0, so rd = 0 on all ports, wdrop = 0. Effective immediately, independent of clk.

## Timing
- Write-to-read latency: data written at edge N is visible on rd from just after edge N (same cycle, combinational read of new contents).
- Read of wa during the cycle we=1 (before the edge): returns old contents unless bypass enabled (see Configuration).
- Clear: clr high at edge N -> busy=1 from edge N through edge N+DEPTH-1; busy=0 after edge N+DEPTH-1. Register k (1..DEPTH-1) is zero after edge N+k. Total DEPTH-1 busy cycles (31 at default).
- clr may be held high; a new clear starts only on an edge where state is IDLE, so back-to-back clr gives one idle cycle between runs... no: clr sampled in IDLE at edge N+DEPTH-1 is not seen (state still CLEAR); the next run starts at edge N+DEPTH.

## Configuration
- REGFILE_BYPASS_EN defined: write-first bypass. For each port, if we=1, busy=0, wa!=0 and ra_i==wa, rd_i = wd in the same cycle (before the edge). Bypass never applies to address 0 or to dropped writes.
- Not defined: no bypass; rd_i reflects stored contents only; new data appears after the edge.

## Test plan
- Read during update: write reg5=0xDEADBEEF, then same cycle we=1 wa=5 wd=0x12345678, ra0=5 -> before edge rd0=0xDEADBEEF (no macro) or 0x12345678 (REGFILE_BYPASS_EN); after edge 0x12345678 in both builds.
- Dual read same register: reg9=0xA5A5A5A5, ra0=ra1=9 -> rd0=rd1=0xA5A5A5A5; ra0=ra1=0 -> both 0.
- Register zero: we=1 wa=0 wd=0xFFFFFFFF -> rd for ra=0 stays 0, with and without bypass.
- Reset: fill regs 1..31 with index value, assert reset mid-cycle (no clock edge) -> all rd ports 0 immediately, busy=0; after release, reads of 1..31 return 0.
- Clear sequence: fill regs 1..31 with 0x100+k, pulse clr at edge N -> busy high 31 cycles; after edge N+3 reg3=0, reg4=0x104; we=1 during busy -> wdrop=1, write lost; after busy falls all regs 0 and a write to reg7 succeeds.
- Reset mid-clear: clr at edge N, reset between edges N+10 and N+11 -> busy 0 at once, all regs 0, next clr starts a full 31-cycle run.
